// File: rtl/rv_pkg.sv
// Shared RootVoter definitions: pair-vector sizing and the pair-index mapping.
package rv_pkg;

  localparam int unsigned RV_MAX_PAIRS = 120;
  localparam int unsigned RV_CNT_W     = 4;
  localparam int unsigned RV_PIDX_W    = 7;

  // Flat index of pair (i,j), i < j, in the upper-triangle enumeration for m datasets.
  function automatic int unsigned pair_idx(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned m);
    return i * m - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/counter.sv
// Timeout down-counter: load has priority, enabled decrement saturates at zero.
module counter #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DWIDTH-1:0] d,
  input  logic              en,
  output logic              expired
);

  logic [DWIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - DWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/compare_unit.sv
// Voting comparator: one dataset row per enabled cycle, producing per-dataset
// match counts and a pairwise equality vector; done is sticky until reset.
module compare_unit
  import rv_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = 64,
  parameter int unsigned MAX_DATASETS   = 9,
  parameter int unsigned COUNT_MATCHES  = 1,
  parameter int unsigned LIST_MATCHES   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [REG_DATA_WIDTH-1:0] sets [MAX_DATASETS],
  input  logic [3:0]                used_datasets,
  output logic [RV_CNT_W-1:0]       match_cnt [MAX_DATASETS],
  output logic [RV_MAX_PAIRS-1:0]   match_vector,
  output logic                      done
);

  logic [3:0]              r_q, r_d;
  logic [RV_CNT_W-1:0]     cnt_q [MAX_DATASETS];
  logic [RV_CNT_W-1:0]     cnt_d [MAX_DATASETS];
  logic [RV_MAX_PAIRS-1:0] vec_q, vec_d;
  logic                    done_q, done_d;

  logic [3:0]                n;
  logic [REG_DATA_WIDTH-1:0] row_word;
  logic [RV_CNT_W-1:0]       hit;

  always_comb begin
    r_d      = r_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    done_d   = done_q;
    hit      = '0;
    row_word = '0;

    n = ({1'b0, used_datasets} > 5'(MAX_DATASETS)) ? 4'(MAX_DATASETS) : used_datasets;

    for (int i = 0; i < MAX_DATASETS; i++) begin
      if (r_q == 4'(i)) row_word = sets[i];
    end

    if (en && !done_q) begin
      // A pointer at or past N (N=0, or inputs changed mid-run) just terminates.
      if (r_q >= n) begin
        done_d = 1'b1;
      end else begin
        for (int j = 0; j < MAX_DATASETS; j++) begin
          if ((4'(j) < n) && (4'(j) != r_q) && (sets[j] == row_word)) begin
            hit = hit + RV_CNT_W'(1);
          end
        end
        for (int i = 0; i < MAX_DATASETS; i++) begin
          if ((r_q == 4'(i)) && (COUNT_MATCHES != 0)) cnt_d[i] = hit;
          for (int j = i + 1; j < MAX_DATASETS; j++) begin
            if ((r_q == 4'(i)) && (4'(j) < n) && (LIST_MATCHES != 0)) begin
              vec_d[RV_PIDX_W'(pair_idx(i, j, MAX_DATASETS))] = (sets[i] == sets[j]);
            end
          end
        end
        r_d = r_q + 4'd1;
        if (r_q == n - 4'd1) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      cnt_q  <= '{default: '0};
      vec_q  <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      done_q <= done_d;
    end
  end

  assign match_cnt    = cnt_q;
  assign match_vector = vec_q;
  assign done         = done_q;

endmodule

// File: tb/tb_compare_unit.sv
// Self-checking bench for compare_unit (both option settings) and the timeout counter.
module tb_compare_unit;

  localparam int M = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [63:0] sets [M];
  logic [3:0]  used_datasets;
  logic [3:0]  cnt_a [M];
  logic [3:0]  cnt_b [M];
  logic [119:0] vec_a, vec_b;
  logic        done_a, done_b;

  logic        cload, cen, cexp;
  logic [7:0]  cd;

  int checks = 0;
  int errors = 0;

  int           exp_cnt [M];
  logic [119:0] exp_vec;

  always #5 clk = ~clk;

  compare_unit #(.REG_DATA_WIDTH(64), .MAX_DATASETS(M), .COUNT_MATCHES(1), .LIST_MATCHES(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .sets(sets), .used_datasets(used_datasets),
    .match_cnt(cnt_a), .match_vector(vec_a), .done(done_a));

  compare_unit #(.REG_DATA_WIDTH(64), .MAX_DATASETS(M), .COUNT_MATCHES(0), .LIST_MATCHES(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .sets(sets), .used_datasets(used_datasets),
    .match_cnt(cnt_b), .match_vector(vec_b), .done(done_b));

  counter #(.DWIDTH(8)) u_cnt (
    .clk(clk), .reset(reset), .load(cload), .d(cd), .en(cen), .expired(cexp));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] pack_cnt(input logic [3:0] a [M]);
    logic [35:0] p = '0;
    for (int k = 0; k < M; k++) p[k*4 +: 4] = a[k];
    return p;
  endfunction

  // Expected counts for the first 'rows' rows written, others still zero.
  function automatic logic [35:0] exp_cnt_packed(input int rows);
    logic [35:0] p = '0;
    for (int k = 0; k < rows; k++) p[k*4 +: 4] = 4'(exp_cnt[k]);
    return p;
  endfunction

  // Reference: compare every active pair, enumerating pairs in (i,j) order.
  task automatic build_model(input int nc);
    int p = 0;
    exp_vec = '0;
    for (int k = 0; k < M; k++) begin
      exp_cnt[k] = 0;
      if (k < nc)
        for (int j = 0; j < nc; j++)
          if (j != k && sets[j] == sets[k]) exp_cnt[k]++;
    end
    for (int i = 0; i < M; i++)
      for (int j = i + 1; j < M; j++) begin
        if (j < nc) exp_vec[p] = (sets[i] == sets[j]);
        p++;
      end
  endtask

  task automatic restart();
    en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_case(input string name, input int n_in);
    int nc, need;
    nc = (n_in > M) ? M : n_in;
    need = (nc < 1) ? 1 : nc;
    used_datasets = 4'(n_in);
    build_model(nc);
    restart();
    en = 1'b1;
    for (int e = 1; e <= need + 1; e++) begin
      @(negedge clk);
      check({name, "_done"}, 128'(done_a), 128'(e >= need));
      check({name, "_done_b"}, 128'(done_b), 128'(e >= need));
      check({name, "_cnt"}, 128'(pack_cnt(cnt_a)), 128'(exp_cnt_packed((e < nc) ? e : nc)));
    end
    check({name, "_vec"}, 128'(vec_a), 128'(exp_vec));
    check({name, "_cnt_off"}, 128'(pack_cnt(cnt_b)), 128'(0));
    check({name, "_vec_off"}, 128'(vec_b), 128'(0));
    en = 1'b0;
  endtask

  task automatic random_sets(input int alpha);
    logic [63:0] v [4];
    for (int k = 0; k < 4; k++) v[k] = {$urandom, $urandom};
    for (int k = 0; k < M; k++) sets[k] = v[$urandom_range(0, alpha - 1)];
  endtask

  initial begin
    logic [63:0] a, b;
    logic [35:0] snap_cnt;
    logic [119:0] snap_vec;
    int n;
    reset = 1'b0; en = 1'b0; used_datasets = '0; cload = 1'b0; cen = 1'b0; cd = '0;
    for (int k = 0; k < M; k++) sets[k] = '0;
    #12;
    check("rst_done", 128'(done_a), 128'(0));
    check("rst_cnt", 128'(pack_cnt(cnt_a)), 128'(0));
    check("rst_vec", 128'(vec_a), 128'(0));
    check("rst_expired", 128'(cexp), 128'(1));
    @(negedge clk);
    reset = 1'b1;

    a = 64'hA5A5_0123_4567_89AB;
    b = 64'h5A5A_FEDC_BA98_7654;
    for (int k = 0; k < M; k++) sets[k] = 64'(k) + 64'h100;
    sets[0] = a; sets[1] = a; sets[2] = a;
    run_case("agree3", 3);
    check("agree3_bits", 128'(vec_a), 128'((120'(1) << 0) | (120'(1) << 1) | (120'(1) << 8)));
    check("agree3_cnt_lit", 128'(pack_cnt(cnt_a)), 128'(36'h222));

    sets[1] = b;
    run_case("corrupt", 3);
    check("corrupt_cnt_lit", 128'(pack_cnt(cnt_a)), 128'(36'h101));
    check("corrupt_bits", 128'(vec_a), 128'(120'(1) << 1));

    run_case("n0", 0);
    check("n0_cnt_lit", 128'(pack_cnt(cnt_a)), 128'(0));
    random_sets(2);
    run_case("n12", 12);
    random_sets(3);
    run_case("n1", 1);

    for (int t = 0; t < 8; t++) begin
      random_sets($urandom_range(1, 4));
      run_case("rand", $urandom_range(0, 15));
    end

    // Stall: single-cycle enable pulses separated by idle gaps.
    random_sets(2);
    used_datasets = 4'd5;
    build_model(5);
    restart();
    for (int s = 1; s <= 5; s++) begin
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("stall_done", 128'(done_a), 128'(s >= 5));
      check("stall_cnt", 128'(pack_cnt(cnt_a)), 128'(exp_cnt_packed(s)));
      snap_cnt = pack_cnt(cnt_a);
      snap_vec = vec_a;
      repeat (2) @(negedge clk);
      check("stall_frozen_cnt", 128'(pack_cnt(cnt_a)), 128'(exp_cnt_packed(s)));
      check("stall_frozen_done", 128'(done_a), 128'(s >= 5));
      if (s < 5) check("stall_frozen_vec", 128'(vec_a), 128'(snap_vec));
    end
    check("stall_vec", 128'(vec_a), 128'(exp_vec));

    // Asynchronous reset in the middle of a run.
    for (int k = 0; k < M; k++) sets[k] = a;
    used_datasets = 4'd9;
    restart();
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_partial", 128'(pack_cnt(cnt_a)), 128'(36'h8888));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cnt", 128'(pack_cnt(cnt_a)), 128'(0));
    check("mid_rst_vec", 128'(vec_a), 128'(0));
    check("mid_rst_done", 128'(done_a), 128'(0));
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_case("restart", 9);

    // Timeout counter.
    cload = 1'b1; cd = 8'd4;
    @(negedge clk);
    cload = 1'b0; cen = 1'b1;
    check("cnt_loaded", 128'(cexp), 128'(0));
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      check("cnt_down", 128'(cexp), 128'(e >= 4));
    end
    cload = 1'b1; cd = 8'd2; cen = 1'b1;
    @(negedge clk);
    cload = 1'b0;
    check("cnt_load_wins", 128'(cexp), 128'(0));
    @(negedge clk);
    check("cnt_load_wins1", 128'(cexp), 128'(0));
    @(negedge clk);
    check("cnt_load_wins0", 128'(cexp), 128'(1));
    cen = 1'b0; cload = 1'b1; cd = 8'd3;
    @(negedge clk);
    check("cnt_load3", 128'(cexp), 128'(0));
    cd = 8'd0;
    @(negedge clk);
    cload = 1'b0;
    check("cnt_load0", 128'(cexp), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compare_unit.md
# compare_unit

Voting comparator for the RootVoter cell. It compares up to `MAX_DATASETS` redundant data words pairwise. For each dataset it reports how many *other* active datasets match it, and optionally a per-pair equality vector. The FSM uses these results to detect data-corruption failures. A companion timeout down-counter, the `counter` sub-module, is specified here so the FSM can bound the wait for datasets.

## Interface
Parameters:
- `REG_DATA_WIDTH`, 64: width of each dataset word.
- `MAX_DATASETS`, 9: number of dataset inputs. Legal range is 2..16.
- `COUNT_MATCHES`, 1: 1 enables the `match_cnt` outputs; 0 ties every entry to 0.
- `LIST_MATCHES`, 0: 1 enables `match_vector`; 0 ties it to 0.

Ports:
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `en`, in, 1: advance comparison by one row per cycle while high.
- `sets`, in, `REG_DATA_WIDTH` x `MAX_DATASETS`: unpacked array of dataset words.
- `used_datasets`, in, 4: number of active datasets N. Values above `MAX_DATASETS` are clamped to `MAX_DATASETS`.
- `match_cnt`, out, 4 x `MAX_DATASETS`: per-dataset count of matching other datasets.
- `match_vector`, out, 120: pairwise equality bits.
- `done`, out, 1: comparison complete; sticky.

## Operation
- Internal state: a 4-bit row pointer `r`, the registered `match_cnt` array, the registered `match_vector`, and the `done` flag.
- Reset low clears all internal state and all outputs to 0, asynchronously.
- Row step: a step occurs on each rising edge where `en`=1 and `done`=0. If `r` < N, the step does the following:
  - `match_cnt[r]` takes the number of indices j < N with j ≠ r and `sets[j]` == `sets[r]`. Self is excluded, so the range is 0..N-1.
  - For every j in r+1..N-1, bit p(r,j) of `match_vector` takes (`sets[r]` == `sets[j]`).
  - `r` increments by 1.
  - If r == N-1, `done` is set to 1 on the same edge.
- N = 0: the first enabled edge sets `done` and writes nothing.
- Pair index: p(i,j) = i·M − i(i+1)/2 + (j−i−1), for i < j, where M = `MAX_DATASETS`.
  - With M=9: p(0,1)=0, p(0,8)=7, p(1,2)=8, p(7,8)=35.
  - Bits at or above M(M−1)/2 are always 0.
- Entries with index ≥ N are never written and stay 0.
- When `done`=1, further `en` has no effect. Only reset restarts the comparison.
- `sets` and `used_datasets` must stay stable from the first enabled edge until `done`. Changing them mid-run gives undefined results, but the unit must not hang.

## Timing
- `done` rises after exactly max(N,1) enabled edges.
- `match_cnt[k]` is valid from the edge that processes row k.
- The whole `match_vector` and all `match_cnt` entries are final when `done`=1.
- Deasserting `en` freezes `r` and all outputs.
- Asserting reset mid-run aborts the comparison immediately and zeroes every output.

## Structure
- Shared package `rv_pkg` holds:
  - the constant `RV_MAX_PAIRS` = 120;
  - the pair-index function p(i,j).
- Sub-module `counter`, the timeout down-counter:
  - Parameter `DWIDTH` (32).
  - Ports: `clk`, `reset` (async active-low), `load`, `d[DWIDTH]`, `en`, `expired`.
  - Count register resets to 0.
  - `load` has priority and sets count to `d`.
  - Otherwise, `en` with count ≠ 0 decrements by 1; the count saturates at 0.
  - `expired` = (count == 0), combinational.
  - Consequences: `expired` is 1 after reset; load `d`=5 followed by 5 enabled edges gives `expired`=1; load of 0 gives `expired`=1 on the next cycle.
- `compare_unit` instantiates no `counter`. The parent FSM instantiates both blocks side by side.

## Test plan
- Three-way agreement: M=9, N=3, sets = {A,A,A}, `en` held high.
  - `done` rises at the 3rd edge.
  - `match_cnt[0..2]` = 2, all other entries 0.
  - With `LIST_MATCHES`=1: `match_vector` bits 0, 1 and 8 = 1, all others 0.
- Single corruption: N=3, sets = {A,B,A}.
  - `match_cnt` = {1,0,1}.
  - Bit p(0,2)=1 set; bits p(0,1) and p(1,2) clear.
- Stall and reset:
  - `en` pulsed one cycle at a time with gaps: `done` rises only after N high cycles, and outputs are frozen during gaps.
  - Reset asserted mid-run: all outputs 0 immediately.
  - Restart after reset: results correct.
- Edge values:
  - N=0: `done` after 1 edge, all outputs 0.
  - N=12 with M=9: treated as N=9, `done` at the 9th edge.
  - `COUNT_MATCHES`=0: `match_cnt` stays all 0.
- Counter:
  - After reset, `expired`=1.
  - Load 4 then hold `en`: `expired` goes 0 then 1 on the 4th edge, and stays 1.
  - Load and `en` asserted together: load wins.
